text_ram_arbiter: RTL and testbench

TEXT_RAM_ARBITER -- requirements
Module: text_ram_arbiter

---
 rtl/text_ram_arbiter.sv | 175 +++++++++++++++++
 tb/tb_text_ram_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_ram_arbiter.sv
// Single-write-port arbiter for the text character RAM: round-robin keyboard/shell
// writes, plus a scroll engine that copies rows up by one and clears the last row.
module text_ram_arbiter #(
    parameter int COLS = 70,
    parameter int ROWS = 58,
    parameter int AW   = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          kb_req,
    input  logic [AW-1:0] kb_addr,
    input  logic [7:0]    kb_data,
    output logic          kb_gnt,
    input  logic          sh_req,
    input  logic [AW-1:0] sh_addr,
    input  logic [7:0]    sh_data,
    output logic          sh_gnt,
    input  logic          scroll_req,
    output logic          scroll_busy,
    output logic          scroll_done,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [7:0]    ram_wdata,
    output logic [AW-1:0] ram_raddr,
    input  logic [7:0]    ram_rdata,
    output logic          addr_err
);
    localparam int CAP_I = COLS * ROWS;
    localparam int N_I   = COLS * (ROWS - 1);
    localparam logic [AW-1:0] CAP_A   = AW'(CAP_I);
    localparam logic [AW-1:0] LAST_A  = AW'(CAP_I - 1);
    localparam logic [AW-1:0] NLAST_A = AW'(N_I - 1);
    localparam logic [AW-1:0] COLS_A  = AW'(COLS);
    localparam logic [AW-1:0] ONE_A   = AW'(1);

    typedef enum logic [1:0] {IDLE, COPY, CLEAR, DONE} state_t;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic          kb_gnt_q, kb_gnt_d;
    logic          sh_gnt_q, sh_gnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          pend_q, pend_d;
    logic          prio_sh_q, prio_sh_d;
    logic          start;
    logic          kb_ok, sh_ok, pick_sh;
    logic [AW-1:0] sel_addr;
    logic [7:0]    sel_data;

    // A requester still high right after its own grant is the same request, not a new one.
    assign kb_ok = kb_req && !kb_gnt_q;
    assign sh_ok = sh_req && !sh_gnt_q;

    always_comb begin
        state_d   = state_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = '0;
        raddr_d   = raddr_q;
        kb_gnt_d  = 1'b0;
        sh_gnt_d  = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        pend_d    = pend_q;
        prio_sh_d = prio_sh_q;
        start     = 1'b0;
        pick_sh   = 1'b0;
        sel_addr  = kb_addr;
        sel_data  = kb_data;
        case (state_q)
            IDLE: begin
                if (scroll_req) begin
                    start = 1'b1;
                end else if (kb_ok || sh_ok) begin
                    pick_sh = sh_ok && (!kb_ok || prio_sh_q);
                    if (pick_sh) begin
                        sel_addr  = sh_addr;
                        sel_data  = sh_data;
                        sh_gnt_d  = 1'b1;
                        prio_sh_d = 1'b0;
                    end else begin
                        kb_gnt_d  = 1'b1;
                        prio_sh_d = 1'b1;
                    end
                    err_d   = (sel_addr >= CAP_A);
                    we_d    = (sel_addr < CAP_A);
                    waddr_d = sel_addr;
                    wdata_d = sel_data;
                end
            end
            COPY: begin
                if (scroll_req) pend_d = 1'b1;
                // Read runs one cycle ahead of the write; park on the last row once done.
                if (raddr_q < LAST_A) raddr_d = raddr_q + ONE_A;
                we_d    = 1'b1;
                waddr_d = we_q ? waddr_q + ONE_A : '0;
                if (we_q && (waddr_q == NLAST_A)) state_d = CLEAR;
            end
            CLEAR: begin
                if (scroll_req) pend_d = 1'b1;
                if (waddr_q == LAST_A) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = waddr_q + ONE_A;
                end
            end
            DONE: begin
                if (pend_q || scroll_req) begin
                    start  = 1'b1;
                    pend_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (start) begin
            state_d = COPY;
            busy_d  = 1'b1;
            raddr_d = COLS_A;
            waddr_d = '0;
            we_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            raddr_q   <= '0;
            kb_gnt_q  <= 1'b0;
            sh_gnt_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            pend_q    <= 1'b0;
            prio_sh_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            raddr_q   <= raddr_d;
            kb_gnt_q  <= kb_gnt_d;
            sh_gnt_q  <= sh_gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            pend_q    <= pend_d;
            prio_sh_q <= prio_sh_d;
        end
    end

    assign ram_we      = we_q;
    assign ram_waddr   = waddr_q;
    // During COPY the byte read last cycle is written straight through.
    assign ram_wdata   = (state_q == COPY) ? ram_rdata : wdata_q;
    assign ram_raddr   = raddr_q;
    assign kb_gnt      = kb_gnt_q;
    assign sh_gnt      = sh_gnt_q;
    assign scroll_busy = busy_q;
    assign scroll_done = done_q;
    assign addr_err    = err_q;
endmodule

// File: tb/tb_text_ram_arbiter.sv
// Directed bench for text_ram_arbiter with a behavioural RAM and a queue of expected writes.
module tb_text_ram_arbiter;
    localparam int COLS = 70;
    localparam int ROWS = 58;
    localparam int AW   = 13;
    localparam int CAP  = COLS * ROWS;
    localparam int N    = COLS * (ROWS - 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          kb_req = 1'b0, sh_req = 1'b0, scroll_req = 1'b0;
    logic [AW-1:0] kb_addr = '0, sh_addr = '0;
    logic [7:0]    kb_data = '0, sh_data = '0;
    logic          kb_gnt, sh_gnt, scroll_busy, scroll_done;
    logic          ram_we, addr_err;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata = '0;
    logic          preload = 1'b0;

    logic [7:0] mem [0:CAP-1];
    logic [7:0] img [0:CAP-1];

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    text_ram_arbiter #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .kb_req(kb_req), .kb_addr(kb_addr), .kb_data(kb_data), .kb_gnt(kb_gnt),
        .sh_req(sh_req), .sh_addr(sh_addr), .sh_data(sh_data), .sh_gnt(sh_gnt),
        .scroll_req(scroll_req), .scroll_busy(scroll_busy), .scroll_done(scroll_done),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < CAP; i++) mem[i] <= 8'(i / COLS + 1);
        end else if (ram_we === 1'b1 && ram_waddr < CAP) begin
            mem[ram_waddr] <= ram_wdata;
        end
        if (ram_raddr < CAP) ram_rdata <= mem[ram_raddr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (kb_gnt === 1'b1 && sh_gnt === 1'b1) begin
            checks++;
            errors++;
            $error("FAIL both_gnt observed kb_gnt=1 sh_gnt=1 expected at most one");
        end
        if (ram_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_write observed addr=0x%0h data=0x%0h expected no write",
                       ram_waddr, ram_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", 32'(ram_waddr), 32'(mon_e.a));
                check("write_data", 32'(ram_wdata), 32'(mon_e.d));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_wr(input int a, input int d);
        exp_q.push_back('{a: AW'(a), d: 8'(d)});
        img[a] = 8'(d);
    endtask

    // Expected write stream of one scroll, derived from the bench's own RAM image.
    task automatic push_scroll();
        for (int k = 0; k < N; k++) exp_q.push_back('{a: AW'(k), d: img[k + COLS]});
        for (int i = 0; i < COLS; i++) exp_q.push_back('{a: AW'(N + i), d: 8'h00});
        for (int k = 0; k < N; k++) img[k] = img[k + COLS];
        for (int i = 0; i < COLS; i++) img[N + i] = 8'h00;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_ram_we"}, 32'(ram_we), 0);
        check({pfx, "_ram_waddr"}, 32'(ram_waddr), 0);
        check({pfx, "_ram_wdata"}, 32'(ram_wdata), 0);
        check({pfx, "_ram_raddr"}, 32'(ram_raddr), 0);
        check({pfx, "_kb_gnt"}, 32'(kb_gnt), 0);
        check({pfx, "_sh_gnt"}, 32'(sh_gnt), 0);
        check({pfx, "_busy"}, 32'(scroll_busy), 0);
        check({pfx, "_done"}, 32'(scroll_done), 0);
        check({pfx, "_addr_err"}, 32'(addr_err), 0);
    endtask

    initial begin
        logic [1:0] codes [4];
        int n, busy_cnt, done_cnt, d1, d2, g, rel;
        logic [7:0] got, want;

        for (int i = 0; i < CAP; i++) img[i] = 8'h00;

        // Reset state
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Both requesters held: round-robin starting with sh
        push_wr(100, 8'h11); push_wr(200, 8'h22); push_wr(100, 8'h11); push_wr(200, 8'h22);
        sh_addr = AW'(100); sh_data = 8'h11; kb_addr = AW'(200); kb_data = 8'h22;
        sh_req = 1'b1; kb_req = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            tick();
            if (kb_gnt || sh_gnt) begin
                codes[n] = {kb_gnt, sh_gnt};
                $display("rr grant %0d: kb_gnt=%0b sh_gnt=%0b", n, kb_gnt, sh_gnt);
                n++;
            end
        end
        sh_req = 1'b0; kb_req = 1'b0;
        check("rr_grant_count", 32'(n), 4);
        for (int i = 0; i < n; i++)
            check($sformatf("rr_order_%0d", i), 32'(codes[i]), (i % 2 == 0) ? 32'b01 : 32'b10);
        tick(); tick();

        // Single keyboard write
        push_wr(9, 8'h41);
        kb_addr = AW'(9); kb_data = 8'h41; kb_req = 1'b1;
        tick();
        $display("kb write: gnt=%0b we=%0b waddr=%0d wdata=0x%0h", kb_gnt, ram_we, ram_waddr, ram_wdata);
        kb_req = 1'b0;
        check("kb_gnt", 32'(kb_gnt), 1);
        check("kb_we", 32'(ram_we), 1);
        check("kb_waddr", 32'(ram_waddr), 9);
        check("kb_wdata", 32'(ram_wdata), 32'h41);
        check("kb_sh_gnt", 32'(sh_gnt), 0);
        check("kb_addr_err", 32'(addr_err), 0);
        tick();
        check("kb_gnt_one_cycle", 32'(kb_gnt), 0);
        check("kb_we_one_cycle", 32'(ram_we), 0);

        // Out-of-range shell write, then last legal address
        sh_addr = AW'(CAP); sh_data = 8'h55; sh_req = 1'b1;
        tick();
        $display("sh oob: gnt=%0b err=%0b we=%0b", sh_gnt, addr_err, ram_we);
        sh_req = 1'b0;
        check("oob_sh_gnt", 32'(sh_gnt), 1);
        check("oob_addr_err", 32'(addr_err), 1);
        check("oob_we", 32'(ram_we), 0);
        tick();
        check("oob_err_pulse", 32'(addr_err), 0);
        push_wr(CAP - 1, 8'h7e);
        kb_addr = AW'(CAP - 1); kb_data = 8'h7e; kb_req = 1'b1;
        tick();
        $display("kb last addr: gnt=%0b err=%0b we=%0b", kb_gnt, addr_err, ram_we);
        kb_req = 1'b0;
        check("last_kb_gnt", 32'(kb_gnt), 1);
        check("last_addr_err", 32'(addr_err), 0);
        check("last_we", 32'(ram_we), 1);
        tick();
        check("queue_empty_writes", 32'(exp_q.size()), 0);

        // Single scroll over a row-numbered screen
        preload = 1'b1;
        tick();
        preload = 1'b0;
        for (int i = 0; i < CAP; i++) img[i] = 8'(i / COLS + 1);
        push_scroll();
        scroll_req = 1'b1;
        tick();
        scroll_req = 1'b0;
        check("scroll_c0_busy", 32'(scroll_busy), 1);
        check("scroll_c0_raddr", 32'(ram_raddr), COLS);
        check("scroll_c0_we", 32'(ram_we), 0);
        busy_cnt = 1; done_cnt = 0;
        for (int c = 0; c < 5000 && scroll_busy; c++) begin
            tick();
            if (scroll_done) done_cnt++;
            if (scroll_busy) busy_cnt++;
        end
        $display("scroll: busy_cycles=%0d done=%0b", busy_cnt, scroll_done);
        check("scroll_busy_cycles", 32'(busy_cnt), CAP + 1);
        check("scroll_done_at_end", 32'(scroll_done), 1);
        tick();
        if (scroll_done) done_cnt++;
        check("scroll_done_once", 32'(done_cnt), 1);
        check("scroll_queue_empty", 32'(exp_q.size()), 0);
        for (int r = 0; r < ROWS; r++) begin
            want = (r < ROWS - 1) ? 8'(r + 2) : 8'h00;
            got = want;
            for (int c = COLS - 1; c >= 0; c--)
                if (mem[r * COLS + c] !== want) got = mem[r * COLS + c];
            check($sformatf("scroll_row_%0d", r), 32'(got), 32'(want));
        end

        // Second scroll requested mid-scroll with kb waiting throughout
        kb_addr = AW'(50); kb_data = 8'h5a; kb_req = 1'b1;
        push_scroll();
        push_scroll();
        push_wr(50, 8'h5a);
        scroll_req = 1'b1;
        tick();
        scroll_req = 1'b0;
        check("pend_c0_busy", 32'(scroll_busy), 1);
        check("pend_c0_kb_gnt", 32'(kb_gnt), 0);
        d1 = -1; d2 = -1; g = -1; rel = 0;
        for (int c = 0; c < 10000; c++) begin
            tick();
            rel++;
            if (scroll_done) begin
                if (d1 < 0) d1 = rel;
                else d2 = rel;
            end
            if (d1 >= 0 && rel == d1 + 1) check("pend_restart_busy", 32'(scroll_busy), 1);
            if (kb_gnt) begin
                g = rel;
                kb_req = 1'b0;
                break;
            end
            if (rel == 100) scroll_req = 1'b1;
            if (rel == 101) scroll_req = 1'b0;
        end
        $display("pending scroll: done1=%0d done2=%0d kb_gnt=%0d", d1, d2, g);
        check("pend_done1_cycle", 32'(d1), CAP + 1);
        check("pend_done2_cycle", 32'(d2), 2 * (CAP + 1) + 1);
        check("pend_kb_gnt_cycle", 32'(g), 2 * (CAP + 1) + 3);
        tick(); tick();
        check("pend_queue_empty", 32'(exp_q.size()), 0);

        // Reset in the middle of a scroll
        push_scroll();
        scroll_req = 1'b1;
        tick();
        scroll_req = 1'b0;
        repeat (500) tick();
        rst = 1'b1;
        tick();
        $display("mid-scroll reset: busy=%0b we=%0b raddr=%0d", scroll_busy, ram_we, ram_raddr);
        check_all_zero("abort");
        rst = 1'b0;
        exp_q.delete();
        tick();
        check("abort_no_write", 32'(ram_we), 0);
        push_wr(7, 8'h33);
        kb_addr = AW'(7); kb_data = 8'h33; kb_req = 1'b1;
        tick();
        $display("post-reset kb write: gnt=%0b we=%0b waddr=%0d", kb_gnt, ram_we, ram_waddr);
        kb_req = 1'b0;
        check("post_kb_gnt", 32'(kb_gnt), 1);
        check("post_kb_we", 32'(ram_we), 1);
        tick(); tick();
        check("post_ram_byte", 32'(mem[7]), 32'h33);
        check("post_queue_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
